// File: rtl/sipo_deserializer_pkg.sv
// rtl/sipo_deserializer_pkg.sv - package wrapping the shared sequential definitions
package sipo_deserializer_pkg;

`include "seq_defs.vh"

endpackage

// File: rtl/seq_defs.vh
// rtl/seq_defs.vh - shared bit-order encodings and constant clog2 for sequential blocks
`ifndef SEQ_DEFS_VH
`define SEQ_DEFS_VH

localparam int LSB_FIRST = 0;
localparam int MSB_FIRST = 1;

// Bits needed to count 0..n-1; at least 1 so a 2-entry counter still has a bit.
function automatic int clog2(input int n);
  int r;
  int v;
  r = 0;
  v = n - 1;
  while (v > 0) begin
    r = r + 1;
    v = v >> 1;
  end
  if (r < 1) r = 1;
  return r;
endfunction

`endif

// File: rtl/sipo_deserializer_dff_en.sv
// rtl/sipo_deserializer_dff_en.sv - single-bit flop with sync active-high reset and enable
module dff_en (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  // Reset wins over enable; q holds when en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in/parallel-out deserializer with one-word holding register
module sipo_deserializer
  import sipo_deserializer_pkg::clog2;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sin,
  input  logic                    sin_valid,
  output logic [WIDTH-1:0]        dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [clog2(WIDTH)-1:0] bit_cnt,
  output logic                    overrun
);

  localparam int CW = clog2(WIDTH);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [WIDTH-1:0] dout_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [CW-1:0]    bit_cnt_d;
  logic             dout_valid_q;
  logic             dout_valid_d;
  logic             overrun_q;
  logic             overrun_d;
  logic             complete;
  logic             consume;
  logic             hold_free;
  logic             load;

  // Next shift value, word completion, and holding-register / flag updates.
  always_comb begin
    sreg_d       = {sin, sreg_q[WIDTH-1:1]};
    bit_cnt_d    = bit_cnt_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;

    if (MSB_FIRST == sipo_deserializer_pkg::MSB_FIRST) begin
      sreg_d = {sreg_q[WIDTH-2:0], sin};
    end

    // The completed word is sreg_d, i.e. it already contains this cycle's bit.
    complete  = sin_valid && (bit_cnt_q == CW'(WIDTH - 1));
    consume   = dout_valid_q && dout_ready;
    hold_free = !dout_valid_q || dout_ready;
    load      = complete && hold_free;

    if (complete) begin
      bit_cnt_d = '0;
    end else if (sin_valid) begin
      bit_cnt_d = bit_cnt_q + CW'(1);
    end

    // A load on the same edge as a consume keeps valid high: no bubble.
    if (load) begin
      dout_valid_d = 1'b1;
    end else if (consume) begin
      dout_valid_d = 1'b0;
    end

    if (complete && !hold_free) begin
      overrun_d = 1'b1;
    end
  end

  // Counter and control flags; overrun is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bits
    dff_en u_sreg (
      .clk (clk),
      .rst (rst),
      .en  (sin_valid),
      .d   (sreg_d[i]),
      .q   (sreg_q[i])
    );

    dff_en u_dout (
      .clk (clk),
      .rst (rst),
      .en  (load),
      .d   (sreg_d[i]),
      .q   (dout_q[i])
    );
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign bit_cnt    = bit_cnt_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - directed self-checking bench for sipo_deserializer
module tb_sipo_deserializer;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       sin_valid;
  logic       dout_ready;

  logic [7:0] dout_l;
  logic       dout_valid_l;
  logic [2:0] bit_cnt_l;
  logic       overrun_l;

  logic [7:0] dout_m;
  logic       dout_valid_m;
  logic [2:0] bit_cnt_m;
  logic       overrun_m;

  int errors;
  int checks;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .dout       (dout_l),
    .dout_valid (dout_valid_l),
    .dout_ready (dout_ready),
    .bit_cnt    (bit_cnt_l),
    .overrun    (overrun_l)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .dout       (dout_m),
    .dout_valid (dout_valid_m),
    .dout_ready (dout_ready),
    .bit_cnt    (bit_cnt_m),
    .overrun    (overrun_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends w LSB first (bit 0 first) and checks dout_valid of the LSB-first DUT each cycle.
  task automatic send_word(input logic [7:0] w, input logic check_valid, input logic exp_last);
    for (int i = 0; i < 8; i++) begin
      sin       = w[i];
      sin_valid = 1'b1;
      tick();
      if (check_valid) begin
        chk("stream_valid", {31'd0, dout_valid_l}, (i == 7) ? {31'd0, exp_last} : 32'd0);
      end
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    dout_ready = 1'b0;
    tick();
    rst = 1'b0;

    chk("rst_dout",       {24'd0, dout_l},        32'h0);
    chk("rst_dout_valid", {31'd0, dout_valid_l},  32'h0);
    chk("rst_bit_cnt",    {29'd0, bit_cnt_l},     32'h0);
    chk("rst_overrun",    {31'd0, overrun_l},     32'h0);

    // Bits 1,0,1,1,0,0,1,0 in time order.
    dout_ready = 1'b1;
    send_word(8'h4D, 1'b1, 1'b1);
    chk("lsb_word",     {24'd0, dout_l},       32'h4D);
    chk("msb_word",     {24'd0, dout_m},       32'hB2);
    chk("msb_valid",    {31'd0, dout_valid_m}, 32'h1);
    chk("wrap_bit_cnt", {29'd0, bit_cnt_l},    32'h0);
    sin_valid = 1'b0;
    tick();
    chk("one_cycle_valid", {31'd0, dout_valid_l}, 32'h0);
    chk("dout_held",       {24'd0, dout_l},       32'h4D);

    // Gapped input: invalid cycles carry the wrong bit and must be ignored.
    for (int i = 0; i < 8; i++) begin
      sin_valid = 1'b0;
      sin       = ~(8'hA5 >> i) & 1'b1;
      tick();
      chk("gap_bit_cnt_hold", {29'd0, bit_cnt_l}, i);
      sin_valid = 1'b1;
      sin       = (8'hA5 >> i) & 1'b1;
      tick();
      chk("gap_bit_cnt_step", {29'd0, bit_cnt_l}, (i + 1) % 8);
    end
    chk("gap_word",  {24'd0, dout_l},       32'hA5);
    chk("gap_valid", {31'd0, dout_valid_l}, 32'h1);
    sin_valid = 1'b0;
    tick();
    chk("gap_consumed", {31'd0, dout_valid_l}, 32'h0);

    // Back-pressure: second word is dropped and overrun sticks.
    dout_ready = 1'b0;
    send_word(8'h11, 1'b0, 1'b1);
    chk("bp_first",       {24'd0, dout_l},       32'h11);
    chk("bp_first_valid", {31'd0, dout_valid_l}, 32'h1);
    chk("bp_no_overrun",  {31'd0, overrun_l},    32'h0);
    send_word(8'h22, 1'b0, 1'b1);
    chk("bp_kept",    {24'd0, dout_l},       32'h11);
    chk("bp_overrun", {31'd0, overrun_l},    32'h1);
    chk("bp_valid",   {31'd0, dout_valid_l}, 32'h1);
    sin_valid  = 1'b0;
    dout_ready = 1'b1;
    tick();
    chk("bp_drain_valid",   {31'd0, dout_valid_l}, 32'h0);
    chk("bp_overrun_stick", {31'd0, overrun_l},    32'h1);
    chk("bp_drain_dout",    {24'd0, dout_l},       32'h11);
    tick();
    chk("bp_overrun_stick2", {31'd0, overrun_l}, 32'h1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_clears_overrun", {31'd0, overrun_l}, 32'h0);

    // Continuous stream with consumer always ready.
    dout_ready = 1'b1;
    send_word(8'h01, 1'b1, 1'b1);
    chk("stream_w1", {24'd0, dout_l}, 32'h01);
    send_word(8'h02, 1'b1, 1'b1);
    chk("stream_w2", {24'd0, dout_l}, 32'h02);
    send_word(8'h03, 1'b1, 1'b1);
    chk("stream_w3",      {24'd0, dout_l},    32'h03);
    chk("stream_overrun", {31'd0, overrun_l}, 32'h0);
    sin_valid = 1'b0;
    tick();

    // Reset mid-word, then a clean word.
    for (int i = 0; i < 5; i++) begin
      sin       = 1'b1;
      sin_valid = 1'b1;
      tick();
    end
    chk("partial_bit_cnt", {29'd0, bit_cnt_l}, 32'h5);
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    sin_valid = 1'b0;
    chk("mid_rst_bit_cnt", {29'd0, bit_cnt_l}, 32'h0);
    dout_ready = 1'b0;
    send_word(8'h3C, 1'b1, 1'b1);
    chk("fresh_word", {24'd0, dout_l}, 32'h3C);

    // Reset with a pending word: word is lost, no overrun.
    sin_valid = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_pending_valid",   {31'd0, dout_valid_l}, 32'h0);
    chk("rst_pending_dout",    {24'd0, dout_l},       32'h0);
    chk("rst_pending_overrun", {31'd0, overrun_l},    32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
